lzc_norm_pipe: RTL

//  Parametrised, 2-stage pipelined leading-zero counter with valid/ready handshake for range renormalisation.

---
 rtl/lzc_pkg.sv | 22 ++
 rtl/lzc_group.sv | 21 ++
 rtl/lzc_norm_pipe.sv | 131 +++++++++++++
 3 files changed

// File: rtl/lzc_pkg.sv
// Shared types and helpers for the pipelined leading-zero counter.
// Group result struct, group width default and a constant clog2.
package lzc_pkg;

  localparam int GROUP_W_DEF = 4;
  localparam int LZC_MAX_W   = 8;

  typedef struct packed {
    logic                 any_one;
    logic [LZC_MAX_W-1:0] local_lzc;
  } grp_res_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/lzc_group.sv
// Combinational leading-zero count of one GROUP_W-bit slice.
// An all-zero slice reports GROUP_W-1 so an all-zero input totals RANGE_WIDTH-1.
module lzc_group
  import lzc_pkg::*;
#(
  parameter int GROUP_W = GROUP_W_DEF
) (
  input  logic [GROUP_W-1:0] d_i,
  output grp_res_t           res_o
);

  // Scan LSB to MSB; the highest set bit is written last and wins
  always_comb begin
    res_o.any_one   = |d_i;
    res_o.local_lzc = LZC_MAX_W'(GROUP_W - 1);
    for (int i = 0; i < GROUP_W; i++) begin
      if (d_i[i]) res_o.local_lzc = LZC_MAX_W'(GROUP_W - 1 - i);
    end
  end

endmodule

// File: rtl/lzc_norm_pipe.sv
// Two-stage leading-zero counter with valid/ready flow control.
// Define LZC_NORM_SHIFT_EN to also return in_range << lzc_out on norm_out.
module lzc_norm_pipe
  import lzc_pkg::*;
#(
  parameter int RANGE_WIDTH = 16,
  parameter int GROUP_W     = GROUP_W_DEF,
  parameter int D_SIZE      = clog2(RANGE_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [RANGE_WIDTH-1:0] in_range,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [D_SIZE-1:0]      lzc_out,
  output logic                   v,
  output logic [RANGE_WIDTH-1:0] norm_out
);

  localparam int NG    = RANGE_WIDTH / GROUP_W;
  localparam int IDX_W = clog2(NG);

  logic              s1_valid_q;
  logic              s2_valid_q;
  logic              s1_adv;
  logic              s2_adv;
  grp_res_t          grp_d [NG];
  grp_res_t          grp_q [NG];
  logic [IDX_W-1:0]  sel;
  logic [D_SIZE-1:0] lzc_d;
  logic [D_SIZE-1:0] lzc_q;
  logic              v_d;
  logic              v_q;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // Group 0 is the most significant slice
  for (genvar g = 0; g < NG; g++) begin : g_grp
    lzc_group #(
      .GROUP_W(GROUP_W)
    ) u_grp (
      .d_i  (in_range[RANGE_WIDTH-1-g*GROUP_W -: GROUP_W]),
      .res_o(grp_d[g])
    );
  end

  // Stage 1: valid flag and per-group results
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      for (int g = 0; g < NG; g++) grp_q[g] <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        for (int g = 0; g < NG; g++) grp_q[g] <= grp_d[g];
      end
    end
  end

  // Priority select of the first non-zero group; all-zero falls to the last
  always_comb begin
    sel = IDX_W'(NG - 1);
    v_d = 1'b0;
    for (int g = NG - 1; g >= 0; g--) begin
      if (grp_q[g].any_one) sel = IDX_W'(g);
      v_d = v_d | grp_q[g].any_one;
    end
    lzc_d = D_SIZE'(sel) * D_SIZE'(GROUP_W)
          + D_SIZE'(grp_q[sel].local_lzc);
  end

  // Stage 2: valid flag, count and non-zero flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_q <= 1'b0;
      lzc_q      <= '0;
      v_q        <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        lzc_q <= lzc_d;
        v_q   <= v_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign lzc_out   = lzc_q;
  assign v         = v_q;

`ifdef LZC_NORM_SHIFT_EN
  logic [RANGE_WIDTH-1:0] raw_q;
  logic [RANGE_WIDTH-1:0] norm_d;
  logic [RANGE_WIDTH-1:0] norm_q;

  // Raw input travels alongside the group results
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      raw_q <= '0;
    end else if (s1_adv && in_valid) begin
      raw_q <= in_range;
    end
  end

  // Log2-level barrel shifter driven by the selected count
  always_comb begin
    norm_d = raw_q;
    for (int k = 0; k < D_SIZE; k++) begin
      if (lzc_d[k]) norm_d = norm_d << (1 << k);
    end
  end

  // Normalised value registered with the count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      norm_q <= '0;
    end else if (s2_adv && s1_valid_q) begin
      norm_q <= norm_d;
    end
  end

  assign norm_out = norm_q;
`else
  assign norm_out = '0;
`endif

endmodule
